// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with a one-word valid/ready output buffer.
// Optional even-parity frame bit and dout_perr port enabled by defining PARITY_EN.
module sipo_deser #(
  parameter int unsigned BIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din,
  input  logic           din_vld,
  output logic           din_rdy,
  output logic [BIT-1:0] dout,
  output logic           dout_vld,
`ifdef PARITY_EN
  output logic           dout_perr,
`endif
  input  logic           dout_rdy
);

`ifdef PARITY_EN
  localparam int unsigned FRAME = BIT + 1;
`else
  localparam int unsigned FRAME = BIT;
`endif
  localparam int unsigned CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  logic [BIT-1:0]   sh;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;
  logic [BIT-1:0]   sh_next;
  logic [BIT-1:0]   word;

  // Only the final bit of a frame can stall, and only while the previous word is still held.
  assign last_bit = (cnt == CNT_LAST);
  assign din_rdy  = !(last_bit && dout_vld && !dout_rdy);
  assign accept   = din_vld && din_rdy;
  assign sh_next  = {sh[BIT-2:0], din};

`ifdef PARITY_EN
  assign word = sh;
`else
  logic sh_msb_unused;
  assign word          = sh_next;
  assign sh_msb_unused = sh[BIT-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh       <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
`ifdef PARITY_EN
      dout_perr <= 1'b0;
`endif
    end else begin
      if (accept) begin
        sh  <= sh_next;
        cnt <= last_bit ? '0 : cnt + CNT_W'(1);
      end
      // A load on the same edge as a drain keeps dout_vld high, so no bubble.
      if (accept && last_bit) begin
        dout     <= word;
        dout_vld <= 1'b1;
`ifdef PARITY_EN
        dout_perr <= (^sh) ^ din;
`endif
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule
